// File: rtl/pci_mon_pkg.sv
// Shared types and check indices for the PCI bus protocol monitor.
package pci_mon_pkg;

  localparam int NCHK = 6;

  localparam int CHK_FRAME_IRDY  = 0;
  localparam int CHK_TRDY_DEVSEL = 1;
  localparam int CHK_ABORT       = 2;
  localparam int CHK_IRDY_IDLE   = 3;
  localparam int CHK_BURST       = 4;
  localparam int CHK_CBE_STABLE  = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DATA  = 3'd2,
    ST_ABORT = 3'd3,
    ST_TURN  = 3'd4
  } pci_state_e;

endpackage

// File: rtl/pci_protocol_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module pci_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pci_protocol_monitor.sv
// Passive PCI bus monitor: phase tracking, rule checks with pulse/sticky flags,
// beat and transaction counters. The bus is only sampled, never driven.
module pci_protocol_monitor
  import pci_mon_pkg::*;
#(
  parameter int AD_W      = 32,
  parameter int CBE_W     = AD_W / 8,
  parameter int DEVSEL_TO = 5,
  parameter int MAX_BEATS = 16,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             FRAME_,
  input  logic             IRDY_,
  input  logic             TRDY_,
  input  logic             DEVSEL_,
  input  logic [CBE_W-1:0] C_BE_,
  input  logic [AD_W-1:0]  AD,
  input  logic [NCHK-1:0]  chk_en,
  input  logic             clr_err,
  output logic [NCHK-1:0]  err_pulse,
  output logic [NCHK-1:0]  err_sticky,
  output logic             abort,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] beat_cnt,
  output logic [CNT_W-1:0] txn_cnt,
  output logic [CBE_W-1:0] last_cmd,
  output logic [AD_W-1:0]  last_addr
);

  localparam int TMR_W = $clog2(DEVSEL_TO + 1);

  pci_state_e       state_q, state_d;
  logic             frame_prev_q;
  logic [CBE_W-1:0] cbe_prev_q;
  logic             data_prev_q;
  logic [NCHK-1:0]  err_pulse_q, err_sticky_q, err_d;
  logic             abort_q;
  logic [CBE_W-1:0] last_cmd_q;
  logic [AD_W-1:0]  last_addr_q;
  logic [TMR_W-1:0] timer_q;

  logic frame_fall, beat, in_data, tmo, addr_phase, txn_inc;

  assign frame_fall = frame_prev_q && !FRAME_;
  assign beat       = !IRDY_ && !TRDY_;
  assign in_data    = (state_q == ST_DATA);
  // Timeout fires on the DATA cycle that would bring the timer to DEVSEL_TO.
  assign tmo        = in_data && DEVSEL_ && ((int'(timer_q) + 1) >= DEVSEL_TO);
  assign txn_inc    = in_data && beat && FRAME_ && !tmo;

  always_comb begin
    state_d    = state_q;
    addr_phase = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (frame_fall) begin
          state_d    = ST_ADDR;
          addr_phase = 1'b1;
        end
      end
      ST_ADDR:  state_d = ST_DATA;
      ST_DATA: begin
        if (tmo) begin
          state_d = ST_ABORT;
        end else if (beat && FRAME_) begin
          state_d = ST_TURN;
        end
      end
      ST_ABORT: begin
        if (FRAME_ && IRDY_) begin
          state_d = ST_TURN;
        end
      end
      ST_TURN: begin
        if (frame_fall) begin
          state_d    = ST_ADDR;
          addr_phase = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    err_d                  = '0;
    err_d[CHK_FRAME_IRDY]  = !frame_prev_q && FRAME_ && IRDY_;
    err_d[CHK_TRDY_DEVSEL] = !TRDY_ && DEVSEL_;
    err_d[CHK_ABORT]       = tmo;
    err_d[CHK_IRDY_IDLE]   = (state_q == ST_IDLE) && !IRDY_;
    err_d[CHK_BURST]       = in_data && beat && (beat_cnt == CNT_W'(MAX_BEATS));
    // Only compare against a C_BE_ sampled in a previous DATA cycle, not the command.
    err_d[CHK_CBE_STABLE]  = in_data && data_prev_q && !IRDY_ && TRDY_ &&
                             (C_BE_ != cbe_prev_q);
    err_d                  = err_d & chk_en;
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      state_q      <= ST_IDLE;
      frame_prev_q <= 1'b1;
      cbe_prev_q   <= '1;
      data_prev_q  <= 1'b0;
      err_pulse_q  <= '0;
      err_sticky_q <= '0;
      abort_q      <= 1'b0;
      last_cmd_q   <= '0;
      last_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      frame_prev_q <= FRAME_;
      cbe_prev_q   <= C_BE_;
      data_prev_q  <= in_data;
      err_pulse_q  <= err_d;
      // A pulse coinciding with clr_err keeps its sticky bit set.
      err_sticky_q <= (err_sticky_q & ~{NCHK{clr_err}}) | err_pulse_q;
      abort_q      <= tmo;
      if (addr_phase) begin
        last_cmd_q  <= C_BE_;
        last_addr_q <= AD;
      end
    end
  end

  pci_sat_counter #(.W(CNT_W)) u_beat_cnt (
    .clk    (clk),
    .reset_ (reset_),
    .clr_i  (addr_phase),
    .inc_i  (in_data && beat),
    .cnt_o  (beat_cnt)
  );

  pci_sat_counter #(.W(CNT_W)) u_txn_cnt (
    .clk    (clk),
    .reset_ (reset_),
    .clr_i  (1'b0),
    .inc_i  (txn_inc),
    .cnt_o  (txn_cnt)
  );

  pci_sat_counter #(.W(TMR_W)) u_devsel_tmr (
    .clk    (clk),
    .reset_ (reset_),
    .clr_i  (addr_phase),
    .inc_i  (in_data && DEVSEL_),
    .cnt_o  (timer_q)
  );

  assign err_pulse  = err_pulse_q;
  assign err_sticky = err_sticky_q;
  assign abort      = abort_q;
  assign state      = state_q;
  assign last_cmd   = last_cmd_q;
  assign last_addr  = last_addr_q;

endmodule

// File: tb/tb_pci_protocol_monitor.sv
// Directed bench for pci_protocol_monitor: per-cycle expected phase/flags via a queue.
module tb_pci_protocol_monitor;
  import pci_mon_pkg::*;

  logic        clk = 1'b0;
  logic        reset_;
  logic        FRAME_, IRDY_, TRDY_, DEVSEL_;
  logic [3:0]  C_BE_;
  logic [31:0] AD;
  logic [5:0]  chk_en;
  logic        clr_err;
  logic [5:0]  err_pulse, err_sticky;
  logic        abort;
  logic [2:0]  state;
  logic [15:0] beat_cnt, txn_cnt;
  logic [3:0]  last_cmd;
  logic [31:0] last_addr;

  logic [9:0]  exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  pci_protocol_monitor dut (
    .clk        (clk),
    .reset_     (reset_),
    .FRAME_     (FRAME_),
    .IRDY_      (IRDY_),
    .TRDY_      (TRDY_),
    .DEVSEL_    (DEVSEL_),
    .C_BE_      (C_BE_),
    .AD         (AD),
    .chk_en     (chk_en),
    .clr_err    (clr_err),
    .err_pulse  (err_pulse),
    .err_sticky (err_sticky),
    .abort      (abort),
    .state      (state),
    .beat_cnt   (beat_cnt),
    .txn_cnt    (txn_cnt),
    .last_cmd   (last_cmd),
    .last_addr  (last_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic bus_idle();
    FRAME_  = 1'b1;
    IRDY_   = 1'b1;
    TRDY_   = 1'b1;
    DEVSEL_ = 1'b1;
    C_BE_   = 4'hF;
    AD      = '0;
  endtask

  // Drive one bus sample; expectation is what must be visible after that edge.
  task automatic cyc(input logic f, input logic i, input logic t, input logic d,
                     input logic [3:0] cbe, input logic [31:0] ad,
                     input logic [2:0] ex_st, input logic [5:0] ex_p, input logic ex_ab);
    logic [9:0] e;
    FRAME_  = f;
    IRDY_   = i;
    TRDY_   = t;
    DEVSEL_ = d;
    C_BE_   = cbe;
    AD      = ad;
    exp_q.push_back({ex_st, ex_p, ex_ab});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("state", state, e[9:7]);
    check("err_pulse", err_pulse, e[6:1]);
    check("abort", abort, e[0]);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_state"}, state, ST_IDLE);
    check({tag, "_pulse"}, err_pulse, 0);
    check({tag, "_sticky"}, err_sticky, 0);
    check({tag, "_abort"}, abort, 0);
    check({tag, "_beat"}, beat_cnt, 0);
    check({tag, "_txn"}, txn_cnt, 0);
    check({tag, "_cmd"}, last_cmd, 0);
    check({tag, "_addr"}, last_addr, 0);
  endtask

  task automatic single_write(input logic [31:0] addr, input logic [3:0] cmd);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, cmd, addr, ST_ADDR, 6'h00, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, $urandom, ST_DATA, 6'h00, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, $urandom, ST_TURN, 6'h00, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 32'h0, ST_IDLE, 6'h00, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a2;
    clr_err = 1'b0;
    chk_en  = '1;
    bus_idle();
    reset_  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_ = 1'b1;
    check_zero("reset");

    // Single write
    single_write(32'h1000_0040, 4'h7);
    check("w1_txn", txn_cnt, 1);
    check("w1_beat", beat_cnt, 1);
    check("w1_addr", last_addr, 32'h1000_0040);
    check("w1_cmd", last_cmd, 4'h7);
    check("w1_sticky", err_sticky, 0);

    // 17-beat burst trips the burst-length check on the last beat
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'h7, 32'h2000_0000, ST_ADDR, 6'h00, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, $urandom, ST_DATA, 6'h00, 1'b0);
    for (int k = 1; k <= 16; k++)
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'($urandom_range(0, 15)), $urandom, ST_DATA, 6'h00, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, $urandom, ST_TURN, 6'h10, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 32'h0, ST_IDLE, 6'h00, 1'b0);
    check("burst_sticky", err_sticky, 6'h10);
    check("burst_beat", beat_cnt, 17);
    check("burst_txn", txn_cnt, 2);
    clr_err = 1'b1;
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 32'h0, ST_IDLE, 6'h00, 1'b0);
    clr_err = 1'b0;
    check("clr_sticky", err_sticky, 0);

    // DEVSEL_ never asserts: master abort on DATA cycle 5
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'h6, 32'h3000_0000, ST_ADDR, 6'h00, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 32'h0, ST_DATA, 6'h00, 1'b0);
    for (int k = 1; k <= 4; k++)
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 32'h0, ST_DATA, 6'h00, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 32'h0, ST_ABORT, 6'h04, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 4'h0, 32'h0, ST_ABORT, 6'h00, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 32'h0, ST_TURN, 6'h00, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 32'h0, ST_IDLE, 6'h00, 1'b0);
    check("abort_txn", txn_cnt, 2);
    check("abort_sticky", err_sticky, 6'h04);

    // TRDY_ without DEVSEL_, enabled then masked, then combined with IRDY_ in IDLE
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 4'hF, 32'h0, ST_IDLE, 6'h02, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 4'hF, 32'h0, ST_IDLE, 6'h02, 1'b0);
    chk_en[CHK_TRDY_DEVSEL] = 1'b0;
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 4'hF, 32'h0, ST_IDLE, 6'h00, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 4'hF, 32'h0, ST_IDLE, 6'h00, 1'b0);
    chk_en = '1;
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'hF, 32'h0, ST_IDLE, 6'h0A, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 32'h0, ST_IDLE, 6'h00, 1'b0);

    // FRAME_ released while IRDY_ is still high
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'h2, 32'h4000_0000, ST_ADDR, 6'h00, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 32'h0, ST_DATA, 6'h01, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, ST_TURN, 6'h00, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 32'h0, ST_IDLE, 6'h00, 1'b0);
    check("f_txn", txn_cnt, 3);

    // C_BE_ change during a wait state, clr_err collisions, then back-to-back
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'h6, 32'h5000_0000, ST_ADDR, 6'h00, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0, ST_DATA, 6'h00, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0, ST_DATA, 6'h00, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'h3, 32'h0, ST_DATA, 6'h20, 1'b0);
    clr_err = 1'b1;
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'h3, 32'h0, ST_DATA, 6'h00, 1'b0);
    check("clr_same_sticky", err_sticky, 6'h20);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'h3, 32'h0, ST_TURN, 6'h00, 1'b0);
    check("clr_next_sticky", err_sticky, 0);
    clr_err = 1'b0;
    a2 = $urandom;
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'hB, a2, ST_ADDR, 6'h00, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0, ST_DATA, 6'h00, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, ST_TURN, 6'h00, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 32'h0, ST_IDLE, 6'h00, 1'b0);
    check("b2b_txn", txn_cnt, 5);
    check("b2b_addr", last_addr, a2);
    check("b2b_cmd", last_cmd, 4'hB);
    check("b2b_beat", beat_cnt, 1);

    // Reset in the middle of a burst
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'h7, 32'h6000_0000, ST_ADDR, 6'h00, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0, ST_DATA, 6'h00, 1'b0);
    for (int k = 1; k <= 3; k++)
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, $urandom, ST_DATA, 6'h00, 1'b0);
    reset_ = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_ = 1'b1;
    bus_idle();
    check_zero("midrst");
    single_write(32'h7000_0010, 4'h7);
    check("post_txn", txn_cnt, 1);
    check("post_beat", beat_cnt, 1);
    check("post_addr", last_addr, 32'h7000_0010);
    check("post_sticky", err_sticky, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pci_protocol_monitor.md
# pci_protocol_monitor

Synthesizable, parametrised PCI bus protocol monitor. It passively samples the shared bus (FRAME_, IRDY_, TRDY_, DEVSEL_, C_BE_, AD) and tracks each transaction through a phase state machine. It reports rule violations as per-check pulse and sticky flags, and keeps beat and transaction counters. It sits beside the bus model in the lab testbench and can be instantiated in FPGA builds, where simulation-only assertions are unavailable.

## Interface
Parameters:
- AD_W, 32, address/data width; multiple of 8.
- CBE_W, AD_W/8, byte-enable width (derived).
- DEVSEL_TO, 5, cycles after the address phase within which DEVSEL_ must assert; ≥1.
- MAX_BEATS, 16, maximum legal data beats per transaction; ≥1.
- CNT_W, 16, width of the beat and transaction counters.
- NCHK, 6, number of checks (fixed).

Ports:
- clk in 1: single clock; all sampling on the rising edge.
- reset_ in 1: synchronous, active-low reset.
- FRAME_, IRDY_, TRDY_, DEVSEL_ in 1 each: bus controls, active-low.
- C_BE_ in CBE_W: command/byte enables.
- AD in AD_W: address/data.
- chk_en in NCHK: per-check enable mask; a disabled check never flags.
- clr_err in 1: clears err_sticky on the next edge.
- err_pulse out NCHK: one-cycle flag per check.
- err_sticky out NCHK: latched OR of err_pulse.
- abort out 1: one-cycle master-abort event.
- state out 3: current phase, encoding from the package.
- beat_cnt out CNT_W: beats in the current or last transaction.
- txn_cnt out CNT_W: completed transactions since reset.
- last_cmd out CBE_W: C_BE_ captured in the last address phase.
- last_addr out AD_W: AD captured in the last address phase.

## Operation
- States: IDLE, ADDR, DATA, ABORT, TURN.
- IDLE→ADDR: FRAME_ sampled low with previous FRAME_ high. On this edge:
  - capture last_cmd and last_addr;
  - clear beat_cnt;
  - clear the DEVSEL timer.
- ADDR→DATA: unconditional, after one cycle.
- DATA:
  - A beat is !IRDY_ && !TRDY_; beat_cnt increments and saturates at all-ones.
  - Beat with FRAME_ high → TURN; txn_cnt increments (saturating).
  - DEVSEL timer counts DATA cycles while DEVSEL_ is high. When it reaches DEVSEL_TO with DEVSEL_ still high → ABORT, and abort pulses once.
- ABORT→TURN: when FRAME_ and IRDY_ are both high. Aborted transactions do not increment txn_cnt.
- TURN→IDLE: after one cycle. If FRAME_ falls in TURN, go directly to ADDR (back-to-back transactions).
- Checks (bit index). Each bit is gated by chk_en and evaluated on every edge unless stated:
  - 0: FRAME_ rises while IRDY_ is high (end of cycle without master ready).
  - 1: TRDY_ low while DEVSEL_ high.
  - 2: master abort (mirrors abort).
  - 3: IRDY_ low in IDLE.
  - 4: beat when beat_cnt == MAX_BEATS (beat MAX_BEATS+1 or later).
  - 5: C_BE_ changes between consecutive DATA cycles while IRDY_ low and TRDY_ high (wait state), using the registered previous C_BE_.
- err_sticky ← (err_sticky & ~{NCHK{clr_err}}) | err_pulse. A pulse in the same cycle as clr_err wins, so its bit stays set.

## Timing
- Reset (reset_ low at an edge) zeroes all registers:
  - state = IDLE; prev FRAME_/C_BE_ registers = all-ones (idle bus);
  - err_pulse, err_sticky, abort, beat_cnt, txn_cnt, last_cmd, last_addr, timer = 0.
- Reset asserted mid-transaction abandons it; no count or flag results.
- Latency:
  - err_pulse and abort are registered and appear one cycle after the violating sample.
  - state, counters and captures update on the sampling edge.
- A violation persisting N cycles yields N consecutive pulses.
- Simultaneous violations set multiple bits in the same cycle.
- DEVSEL_TO=1: abort on the first DATA cycle with DEVSEL_ high.
- Counter saturation holds the value at all-ones; there is no wrap.

## Structure
- Package pci_mon_pkg holds:
  - state enum typedef;
  - check-index localparams CHK_FRAME_IRDY, CHK_TRDY_DEVSEL, CHK_ABORT, CHK_IRDY_IDLE, CHK_BURST, CHK_CBE_STABLE;
  - NCHK.
- One sub-module, pci_sat_counter (parametrised width, inc/clr, saturating), used for beat_cnt, txn_cnt and the DEVSEL timer.

## Test plan
- Single write: cmd 4'h7, addr 32'h1000_0040, DEVSEL_ on cycle 2, one beat with FRAME_ high → state ADDR→DATA→TURN→IDLE; txn_cnt=1, beat_cnt=1, last_addr=32'h1000_0040, no flags.
- Burst of 17 beats, MAX_BEATS=16 → err_pulse[4] one cycle after beat 17; err_sticky[4]=1; beat_cnt=17.
- DEVSEL_ held high, DEVSEL_TO=5 → abort and err_pulse[2] on DATA cycle 5 (+1 registration); state ABORT until FRAME_ and IRDY_ high; txn_cnt unchanged.
- TRDY_ low with DEVSEL_ high for 2 cycles, chk_en[1]=1 → two pulses on bit 1. Repeat with chk_en[1]=0 → no pulse.
- C_BE_ 4'h0→4'h3 during an IRDY_-low/TRDY_-high wait → err_pulse[5]. clr_err in the same cycle → err_sticky[5] stays 1. clr_err on the next cycle → cleared.
- reset_ low mid-burst → all outputs 0, state IDLE. A following legal transaction completes with txn_cnt=1.
